// File: rtl/count_prescaled_multi_if.sv
// Control/status bundle for the prescaled counter: step controls in, LED count and
// memory address stimulus out.
interface count_prescaled_multi_if #(
  parameter int unsigned PRESCALE_W = 27,
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned ADDR_W     = 10
);
  logic                  clk_en;
  logic [PRESCALE_W-1:0] prescale_max;
  logic                  dir;
  logic                  load;
  logic [CNT_W-1:0]      load_val;
  logic [CNT_W-1:0]      count_out;
  logic                  tick;
  logic                  bound;
  logic [ADDR_W-1:0]     addra;
  logic [ADDR_W-1:0]     addrb;

  modport master (
    output clk_en, prescale_max, dir, load, load_val,
    input  count_out, tick, bound, addra, addrb
  );

  modport slave (
    input  clk_en, prescale_max, dir, load, load_val,
    output count_out, tick, bound, addra, addrb
  );
endinterface

// File: rtl/count_prescaled_multi.sv
// Programmable-prescaler up/down counter (wrap or saturate) with synchronous load,
// plus two free-running address pointers advanced on every step event.
module count_prescaled_multi #(
  parameter int unsigned           PRESCALE_W = 27,
  parameter int unsigned           CNT_W      = 8,
  parameter int unsigned           ADDR_W     = 10,
  parameter logic [ADDR_W-1:0]     ADDRB_INIT = ADDR_W'('h3F0),
  parameter bit                    SATURATE   = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  count_prescaled_multi_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PRESCALE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [CNT_W-1:0]      count_q,   count_d;
  logic                  tick_q,    tick_d;
  logic                  bound_q,   bound_d;
  logic [ADDR_W-1:0]     addra_q,   addra_d;
  logic [ADDR_W-1:0]     addrb_q,   addrb_d;

  logic term_c;
  logic step_c;
  logic at_bound_c;

  // >= so a lowered prescale_max terminates immediately instead of wrapping pre_cnt
  assign term_c     = bus.clk_en && (pre_cnt_q >= bus.prescale_max);
  assign step_c     = term_c && !bus.load;
  assign at_bound_c = bus.dir ? (count_q == '0) : (count_q == CNT_MAX);

  always_comb begin
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    tick_d    = 1'b0;
    bound_d   = 1'b0;
    addra_d   = addra_q;
    addrb_d   = addrb_q;

    if (bus.load) begin
      count_d   = bus.load_val;
      pre_cnt_d = '0;
    end else if (step_c) begin
      pre_cnt_d = '0;
      tick_d    = 1'b1;
      addra_d   = addra_q + ADDR_W'(1);
      addrb_d   = addrb_q + ADDR_W'(1);
      bound_d   = at_bound_c;
      // Saturate mode holds at the bound; wrap mode relies on modular add/sub
      if (!(SATURATE && at_bound_c)) begin
        count_d = bus.dir ? (count_q - CNT_W'(1)) : (count_q + CNT_W'(1));
      end
    end else if (bus.clk_en) begin
      pre_cnt_d = pre_cnt_q + PRESCALE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q <= '0;
      count_q   <= '0;
      tick_q    <= 1'b0;
      bound_q   <= 1'b0;
      addra_q   <= '0;
      addrb_q   <= ADDRB_INIT;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      tick_q    <= tick_d;
      bound_q   <= bound_d;
      addra_q   <= addra_d;
      addrb_q   <= addrb_d;
    end
  end

  assign bus.count_out = count_q;
  assign bus.tick      = tick_q;
  assign bus.bound     = bound_q;
  assign bus.addra     = addra_q;
  assign bus.addrb     = addrb_q;

endmodule

// File: tb/tb_count_prescaled_multi.sv
// Drives a wrap-mode and a saturate-mode instance with identical stimulus and checks
// both against an arithmetic reference model, with directed and random phases.
module tb_count_prescaled_multi;

  localparam int unsigned PW = 27;
  localparam int unsigned CW = 8;
  localparam int unsigned AW = 10;
  localparam int          BINIT = 'h3F0;

  logic clk = 1'b0;
  logic rst;
  logic          clk_en;
  logic [PW-1:0] prescale_max;
  logic          dir;
  logic          load;
  logic [CW-1:0] load_val;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  count_prescaled_multi_if #(.PRESCALE_W(PW), .CNT_W(CW), .ADDR_W(AW)) bus0 ();
  count_prescaled_multi_if #(.PRESCALE_W(PW), .CNT_W(CW), .ADDR_W(AW)) bus1 ();

  assign bus0.clk_en = clk_en;       assign bus1.clk_en = clk_en;
  assign bus0.prescale_max = prescale_max; assign bus1.prescale_max = prescale_max;
  assign bus0.dir = dir;             assign bus1.dir = dir;
  assign bus0.load = load;           assign bus1.load = load;
  assign bus0.load_val = load_val;   assign bus1.load_val = load_val;

  count_prescaled_multi #(.PRESCALE_W(PW), .CNT_W(CW), .ADDR_W(AW),
    .ADDRB_INIT(AW'(BINIT)), .SATURATE(1'b0)) u_wrap (.clk(clk), .rst(rst), .bus(bus0));
  count_prescaled_multi #(.PRESCALE_W(PW), .CNT_W(CW), .ADDR_W(AW),
    .ADDRB_INIT(AW'(BINIT)), .SATURATE(1'b1)) u_sat  (.clk(clk), .rst(rst), .bus(bus1));

  logic [31:0] o_cnt [2];
  logic [31:0] o_tick[2];
  logic [31:0] o_bnd [2];
  logic [31:0] o_a   [2];
  logic [31:0] o_b   [2];
  assign o_cnt[0] = 32'(bus0.count_out); assign o_cnt[1] = 32'(bus1.count_out);
  assign o_tick[0] = 32'(bus0.tick);     assign o_tick[1] = 32'(bus1.tick);
  assign o_bnd[0] = 32'(bus0.bound);     assign o_bnd[1] = 32'(bus1.bound);
  assign o_a[0] = 32'(bus0.addra);       assign o_a[1] = 32'(bus1.addra);
  assign o_b[0] = 32'(bus0.addrb);       assign o_b[1] = 32'(bus1.addrb);

  // Reference state, index 0 = wrap instance, 1 = saturate instance
  longint m_pre [2];
  int     m_cnt [2];
  int     m_tick[2];
  int     m_bnd [2];
  int     m_a   [2];
  int     m_b   [2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_pre[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_bnd[i] = 0;
        m_a[i] = 0; m_b[i] = BINIT;
      end else if (load) begin
        m_cnt[i] = int'(load_val); m_pre[i] = 0; m_tick[i] = 0; m_bnd[i] = 0;
      end else begin
        m_tick[i] = 0; m_bnd[i] = 0;
        if (clk_en && m_pre[i] >= longint'(prescale_max)) begin
          int nxt;
          m_pre[i]  = 0;
          m_tick[i] = 1;
          m_a[i] = (m_a[i] + 1) % (1 << AW);
          m_b[i] = (m_b[i] + 1) % (1 << AW);
          nxt = m_cnt[i] + (dir ? -1 : 1);
          if (nxt < 0 || nxt >= (1 << CW)) begin
            m_bnd[i] = 1;
            if (i == 0) m_cnt[i] = (nxt + (1 << CW)) % (1 << CW);
          end else begin
            m_cnt[i] = nxt;
          end
        end else if (clk_en) begin
          m_pre[i]++;
        end
      end
    end
  endtask

  // One clock: update model with the inputs present at the edge, then compare everything
  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("u%0d.count", i), o_cnt[i],  32'(m_cnt[i]));
      check_eq($sformatf("u%0d.tick", i),  o_tick[i], 32'(m_tick[i]));
      check_eq($sformatf("u%0d.bound", i), o_bnd[i],  32'(m_bnd[i]));
      check_eq($sformatf("u%0d.addra", i), o_a[i],    32'(m_a[i]));
      check_eq($sformatf("u%0d.addrb", i), o_b[i],    32'(m_b[i]));
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int k = 0; k < n; k++) cyc();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; prescale_max = PW'(3); dir = 1'b0; load = 1'b0; load_val = '0;
    for (int i = 0; i < 2; i++) begin
      m_pre[i] = 0; m_cnt[i] = 0; m_tick[i] = 0; m_bnd[i] = 0; m_a[i] = 0; m_b[i] = BINIT;
    end

    // Reset values, then first tick on 4th edge after release
    do_reset(3);
    check_eq("rst.count", o_cnt[0], 32'h0);
    check_eq("rst.addra", o_a[0], 32'h0);
    check_eq("rst.addrb", o_b[0], 32'h3F0);
    check_eq("rst.tick",  o_tick[0], 32'h0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      check_eq("first_tick.tick", o_tick[0], (k == 3) ? 32'h1 : 32'h0);
    end
    check_eq("first_tick.count", o_cnt[0], 32'h1);
    check_eq("first_tick.addra", o_a[0], 32'h1);
    check_eq("first_tick.addrb", o_b[0], 32'h3F1);

    // Down-count wrap and pointer wrap
    do_reset(1);
    prescale_max = '0; dir = 1'b1;
    cyc();
    check_eq("down_wrap.count", o_cnt[0], 32'hFF);
    check_eq("down_wrap.bound", o_bnd[0], 32'h1);
    check_eq("down_sat.count",  o_cnt[1], 32'h0);
    check_eq("down_sat.bound",  o_bnd[1], 32'h1);
    for (int k = 0; k < 1023; k++) cyc();
    check_eq("ptr_wrap.addra", o_a[0], 32'h0);
    check_eq("ptr_wrap.addrb", o_b[0], 32'h3F0);

    // Saturation at top
    do_reset(1);
    load = 1'b1; load_val = 8'hFE; dir = 1'b0; prescale_max = '0;
    cyc();
    load = 1'b0;
    cyc();
    check_eq("sat.count1", o_cnt[1], 32'hFF);
    check_eq("sat.bound1", o_bnd[1], 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("sat.count", o_cnt[1], 32'hFF);
      check_eq("sat.bound", o_bnd[1], 32'h1);
      check_eq("sat.tick",  o_tick[1], 32'h1);
    end

    // Load coincident with terminal count
    do_reset(1);
    prescale_max = PW'(2);
    cyc(); cyc();
    load = 1'b1; load_val = 8'h5A;
    cyc();
    load = 1'b0;
    check_eq("ld_term.count", o_cnt[0], 32'h5A);
    check_eq("ld_term.tick",  o_tick[0], 32'h0);
    check_eq("ld_term.addra", o_a[0], 32'h0);
    for (int k = 0; k < 3; k++) begin
      cyc();
      check_eq("ld_term.next_tick", o_tick[0], (k == 2) ? 32'h1 : 32'h0);
    end

    // Dynamic prescale lowering, then gated enable doubles the period
    do_reset(1);
    prescale_max = PW'(100);
    for (int k = 0; k < 10; k++) cyc();
    prescale_max = PW'(4);
    cyc();
    check_eq("dyn.tick", o_tick[0], 32'h1);
    for (int k = 0; k < 40; k++) begin
      clk_en = (k % 2) == 1;
      cyc();
      check_eq("gate.tick", o_tick[0], (k % 10 == 9) ? 32'h1 : 32'h0);
    end
    clk_en = 1'b1;

    // Reset mid-period
    do_reset(1);
    prescale_max = PW'(7);
    load = 1'b1; load_val = 8'h33;
    cyc();
    load = 1'b0;
    for (int k = 0; k < 5; k++) cyc();
    check_eq("mid.count_pre", o_cnt[0], 32'h33);
    do_reset(1);
    check_eq("mid.count_rst", o_cnt[0], 32'h0);
    check_eq("mid.addrb_rst", o_b[0], 32'h3F0);
    for (int k = 0; k < 8; k++) begin
      cyc();
      check_eq("mid.tick", o_tick[0], (k == 7) ? 32'h1 : 32'h0);
    end

    // Randomized traffic
    for (int k = 0; k < 3000; k++) begin
      rst      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 15) == 0);
      clk_en   = ($urandom_range(0, 3) != 0);
      dir      = 1'($urandom_range(0, 1));
      load_val = CW'($urandom);
      if ($urandom_range(0, 31) == 0)
        prescale_max = PW'($urandom_range(0, 40));
      else if ($urandom_range(0, 7) == 0)
        prescale_max = PW'($urandom_range(0, 5));
      if ($urandom_range(0, 63) == 0) load_val = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
